// File: rtl/vector_alu_pkg.sv
// Shared opcode and FSM state types for the
// lane-parallel vector ALU.
package vector_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD     = 3'b000,
      OP_SUB     = 3'b001,
      OP_DIV     = 3'b010,
      OP_FPMUL   = 3'b011,
      OP_MUL     = 3'b100,
      OP_PASS1   = 3'b101,
      OP_PASS2   = 3'b110,
      OP_PASS1_B = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/vector_div_lane.sv
// One lane of the lockstep restoring divider;
// produces one quotient bit per step.
module vector_div_lane
   import vector_alu_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  step,
   input  logic                  last,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic                  done
);

   logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
   logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH:0]   rem_ext;
   logic                  ge;

   // Divide by zero naturally yields all ones here.
   always_comb begin
      rem_ext = {rem_q, dvd_q[DATA_WIDTH-1]};
      ge      = (rem_ext >= {1'b0, dvs_q});
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      done_d  = done_q;
      if (start) begin
         dvd_d  = a;
         dvs_d  = b;
         rem_d  = '0;
         done_d = 1'b0;
      end else if (step) begin
         rem_d  = ge ? DATA_WIDTH'(rem_ext - {1'b0, dvs_q})
                     : rem_ext[DATA_WIDTH-1:0];
         dvd_d  = (dvd_q << 1) | DATA_WIDTH'(ge);
         done_d = last;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dvd_q  <= '0;
         dvs_q  <= '0;
         rem_q  <= '0;
         done_q <= 1'b0;
      end else begin
         dvd_q  <= dvd_d;
         dvs_q  <= dvs_d;
         rem_q  <= rem_d;
         done_q <= done_d;
      end
   end

   assign quotient = dvd_q;
   assign done     = done_q;

endmodule

// File: rtl/vector_alu_pipe.sv
// Lane-parallel unsigned vector ALU with a
// valid/ready handshake and multi-cycle divide.
module vector_alu_pipe
   import vector_alu_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 6,
   parameter int FRAC_BITS  = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [2:0]                  op,
   input  logic [LANES*DATA_WIDTH-1:0] operand1,
   input  logic [LANES*DATA_WIDTH-1:0] operand2,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*DATA_WIDTH-1:0] out,
   output logic                        busy
);

   localparam int W  = LANES * DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH + 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    out_q, out_d;
   logic            ov_q, ov_d;
   logic [W-1:0]    alu_w;
   logic [W-1:0]    quot_w;
   logic [LANES-1:0] done_w;
   logic            accept;
   logic            div_go;
   logic            step;
   logic            last;

   assign in_ready = (state_q == IDLE) && (!ov_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign div_go   = accept && (op_e'(op) == OP_DIV);
   assign step     = (state_q == DIV);
   assign last     = (cnt_q == CW'(DATA_WIDTH - 1));

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [DATA_WIDTH-1:0]   a, b, res;
      logic [2*DATA_WIDTH-1:0] prod;

      assign a    = operand1[g*DATA_WIDTH +: DATA_WIDTH];
      assign b    = operand2[g*DATA_WIDTH +: DATA_WIDTH];
      assign prod = {{DATA_WIDTH{1'b0}}, a}
                  * {{DATA_WIDTH{1'b0}}, b};

      always_comb begin
         res = a;
         unique case (op_e'(op))
            OP_ADD:   res = a + b;
            OP_SUB:   res = a - b;
            OP_FPMUL: res = DATA_WIDTH'(prod >> FRAC_BITS);
            OP_MUL:   res = DATA_WIDTH'(prod);
            OP_PASS2: res = b;
            default:  res = a;
         endcase
      end

      assign alu_w[g*DATA_WIDTH +: DATA_WIDTH] = res;

      vector_div_lane #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_div (
         .clk      (clk),
         .reset    (reset),
         .start    (div_go),
         .step     (step),
         .last     (last),
         .a        (a),
         .b        (b),
         .quotient (quot_w[g*DATA_WIDTH +: DATA_WIDTH]),
         .done     (done_w[g])
      );
   end

   // HOLD spends its first cycle loading the quotients.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      ov_d    = ov_q;
      unique case (state_q)
         IDLE: begin
            if (ov_q && out_ready) ov_d = 1'b0;
            if (accept) begin
               if (op_e'(op) == OP_DIV) begin
                  state_d = DIV;
                  cnt_d   = '0;
               end else begin
                  out_d = alu_w;
                  ov_d  = 1'b1;
               end
            end
         end
         DIV: begin
            cnt_d = cnt_q + 1'b1;
            if (last) state_d = HOLD;
         end
         HOLD: begin
            if (!ov_q) begin
               if (&done_w) begin
                  out_d = quot_w;
                  ov_d  = 1'b1;
               end
            end else if (out_ready) begin
               ov_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         out_q   <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         ov_q    <= ov_d;
      end
   end

   assign out       = out_q;
   assign out_valid = ov_q;
   assign busy      = (state_q == DIV);

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Directed plus randomized check of vector_alu_pipe
// against an arithmetic lane model.
module tb_vector_alu_pipe;

   localparam int DW = 8;
   localparam int L  = 6;
   localparam int FB = 4;
   localparam int W  = DW * L;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [W-1:0] operand1;
   logic [W-1:0] operand2;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic         busy;

   int n_cmp = 0;
   int n_err = 0;

   vector_alu_pipe #(
      .DATA_WIDTH (DW),
      .LANES      (L),
      .FRAC_BITS  (FB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .operand1  (operand1),
      .operand2  (operand2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] model(
      input logic [2:0] o, input logic [W-1:0] va,
      input logic [W-1:0] vb);
      logic [W-1:0] r;
      longint unsigned x, y, m, z;
      m = 64'd1 << DW;
      r = '0;
      for (int i = 0; i < L; i++) begin
         x = longint'(va[i*DW +: DW]);
         y = longint'(vb[i*DW +: DW]);
         case (o)
            3'd0: z = (x + y) % m;
            3'd1: z = (x + m - y) % m;
            3'd2: z = (y == 0) ? m - 1 : x / y;
            3'd3: z = ((x * y) / (64'd1 << FB)) % m;
            3'd4: z = (x * y) % m;
            3'd6: z = y;
            default: z = x;
         endcase
         r[i*DW +: DW] = DW'(z);
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < L; i++) begin
         operand1[i*DW +: DW] = DW'($urandom);
         operand2[i*DW +: DW] = DW'($urandom);
      end
   endtask

   task automatic send();
      int t;
      t = 0;
      while (!in_ready && t < 50) begin
         tick();
         t++;
      end
      chk("send_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      while (!out_valid && k < 40) begin
         tick();
         k++;
      end
      chk("wait_timeout", 64'(k < 40), 64'd1);
   endtask

   initial begin
      logic [W-1:0] exp, held;
      int k, nbusy, seen, hold;

      // reset, with a request presented during reset
      reset     = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      op        = 3'd0;
      operand1  = '1;
      operand2  = '1;
      repeat (3) tick();
      chk("rst_ov", 64'(out_valid), 64'd0);
      chk("rst_out", 64'(out), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      reset    = 1'b0;
      in_valid = 1'b0;
      chk("rst_rdy", 64'(in_ready), 64'd1);
      tick();
      chk("rst_noacc", 64'(out_valid), 64'd0);

      // ADD with lane-0 wrap
      op = 3'd0;
      for (int i = 0; i < L; i++) begin
         operand1[i*DW +: DW] = 8'd1;
         operand2[i*DW +: DW] = 8'd2;
      end
      operand1[7:0] = 8'd200;
      operand2[7:0] = 8'd100;
      exp = model(op, operand1, operand2);
      send();
      chk("add_ov", 64'(out_valid), 64'd1);
      chk("add_l0", 64'(out[7:0]), 64'd44);
      chk("add_l1", 64'(out[15:8]), 64'd3);
      chk("add_all", 64'(out), 64'(exp));

      // SUB then MUL back to back
      rand_ops();
      op = 3'd1;
      operand1[7:0] = 8'd5;
      operand2[7:0] = 8'd9;
      exp = model(op, operand1, operand2);
      in_valid = 1'b1;
      tick();
      chk("sub_l0", 64'(out[7:0]), 64'd252);
      chk("sub_all", 64'(out), 64'(exp));
      chk("sub_rdy", 64'(in_ready), 64'd1);
      rand_ops();
      op = 3'd4;
      operand1[7:0] = 8'd20;
      operand2[7:0] = 8'd13;
      exp = model(op, operand1, operand2);
      tick();
      chk("mul_ov", 64'(out_valid), 64'd1);
      chk("mul_l0", 64'(out[7:0]), 64'd4);
      chk("mul_all", 64'(out), 64'(exp));
      in_valid = 1'b0;
      tick();
      chk("mul_drain", 64'(out_valid), 64'd0);

      // DIV with a zero divisor lane
      rand_ops();
      op = 3'd2;
      operand1[7:0]  = 8'd100;
      operand2[7:0]  = 8'd7;
      operand1[15:8] = 8'd5;
      operand2[15:8] = 8'd0;
      exp = model(op, operand1, operand2);
      send();
      k = 0;
      nbusy = 0;
      seen = 0;
      while (!out_valid && k < 40) begin
         if (busy) nbusy++;
         if (in_ready) seen = 1;
         tick();
         k++;
      end
      chk("div_lat", 64'(k), 64'd9);
      chk("div_busy", 64'(nbusy), 64'd8);
      chk("div_rdy", 64'(seen), 64'd0);
      chk("div_l0", 64'(out[7:0]), 64'd14);
      chk("div_l1", 64'(out[15:8]), 64'd255);
      chk("div_all", 64'(out), 64'(exp));
      tick();
      chk("div_drain", 64'(out_valid), 64'd0);

      // FPMUL under backpressure; other inputs ignored
      rand_ops();
      op = 3'd3;
      operand1[7:0] = 8'h18;
      operand2[7:0] = 8'h20;
      exp = model(op, operand1, operand2);
      out_ready = 1'b0;
      send();
      chk("fp_l0", 64'(out[7:0]), 64'h30);
      chk("fp_all", 64'(out), 64'(exp));
      held = out;
      in_valid = 1'b1;
      op = 3'd0;
      rand_ops();
      repeat (5) begin
         tick();
         chk("fp_stable", 64'(out), 64'(held));
         chk("fp_ov", 64'(out_valid), 64'd1);
         chk("fp_rdy", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("fp_drain", 64'(out_valid), 64'd0);

      // reset aborts a division
      rand_ops();
      op = 3'd2;
      send();
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      seen = 0;
      repeat (15) begin
         if (out_valid) seen = 1;
         tick();
      end
      chk("abort_none", 64'(seen), 64'd0);
      op = 3'd0;
      for (int i = 0; i < L; i++) begin
         operand1[i*DW +: DW] = 8'd1;
         operand2[i*DW +: DW] = 8'd1;
      end
      send();
      chk("abort_add", 64'(out[7:0]), 64'd2);
      tick();

      // pass-through ops
      rand_ops();
      op = 3'd6;
      for (int i = 0; i < L; i++) operand2[i*DW +: DW] = 8'hAB;
      send();
      chk("pass2", 64'(out), 64'(model(3'd6, operand1, operand2)));
      chk("pass2_l5", 64'(out[47:40]), 64'hAB);
      tick();
      rand_ops();
      op = 3'd7;
      exp = operand1;
      send();
      chk("pass1b", 64'(out), 64'(exp));
      tick();

      // randomized traffic with backpressure
      for (int n = 0; n < 60; n++) begin
         op = 3'($urandom_range(0, 7));
         rand_ops();
         if (op == 3'd2) begin
            for (int i = 0; i < L; i++)
               if ($urandom_range(0, 5) == 0)
                  operand2[i*DW +: DW] = '0;
         end
         exp = model(op, operand1, operand2);
         out_ready = 1'b0;
         send();
         wait_valid(k);
         chk("rnd_out", 64'(out), 64'(exp));
         hold = $urandom_range(0, 2);
         repeat (hold) begin
            tick();
            chk("rnd_hold", 64'(out), 64'(exp));
         end
         out_ready = 1'b1;
         tick();
         chk("rnd_drain", 64'(out_valid), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vector_alu_pipe.md
VECTOR_ALU_PIPE -- requirements
Module: vector_alu_pipe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the lane width in bits.
REQ-002 The block SHALL have parameter LANES, default 6, giving the lane count; any value 1..16 SHALL work, with no lane count hardcoded.
REQ-003 The block SHALL have parameter FRAC_BITS, default 4, giving the fixed-point fraction bits for FPMUL; FRAC_BITS < DATA_WIDTH.
REQ-004 Port list (clock and reset first):
- clk, input, 1 -- the single clock; all logic on its rising edge.
- reset, input, 1 -- synchronous, active-high.
- in_valid, input, 1 -- a request is present.
- in_ready, output, 1 -- the block accepts a request this cycle.
- op, input, 3 -- opcode.
- operand1, input, LANES*DATA_WIDTH -- lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- operand2, input, LANES*DATA_WIDTH -- same packing as operand1.
- out_valid, output, 1 -- a result is held on out.
- out_ready, input, 1 -- the consumer takes the result.
- out, output, LANES*DATA_WIDTH -- result, packed the same way as the operands.
- busy, output, 1 -- high while a division is in progress.

Function
REQ-005 Opcodes SHALL be: 000 ADD, 001 SUB, 010 DIV, 011 FPMUL, 100 MUL, 101 PASS1, 110 PASS2, 111 PASS1.
REQ-006 All arithmetic SHALL be unsigned, per lane, and truncated to DATA_WIDTH bits (wrap mod 2^DATA_WIDTH), with no carries between lanes.
REQ-007 MUL SHALL return the low DATA_WIDTH bits of a*b.
REQ-008 FPMUL SHALL return bits [FRAC_BITS +: DATA_WIDTH] of the 2*DATA_WIDTH-bit product a*b (truncation, no rounding).
REQ-009 DIV SHALL return floor(a/b); when b==0 the lane SHALL return all ones, other lanes unaffected.
REQ-010 A request SHALL be accepted on a rising edge where in_valid && in_ready; op and operands SHALL be captured at acceptance.
REQ-011 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-012 The state machine SHALL have three states, IDLE, DIV, HOLD:
- IDLE --accept DIV--> DIV.
- IDLE --accept other op--> IDLE, with the result registered.
- DIV --counter reaches DATA_WIDTH--> HOLD.
- HOLD --out_ready--> IDLE.
REQ-013 Non-DIV latency SHALL be 1 cycle: a request accepted at edge N gives out_valid high after edge N.
REQ-014 DIV latency SHALL be DATA_WIDTH+1 cycles: all lanes run an iterative restoring divide, one quotient bit per cycle, and out_valid rises after edge N+DATA_WIDTH+1.
REQ-015 out and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-016 With out_valid && out_ready in IDLE and a new non-DIV accept in the same cycle, the new result SHALL replace the old with no bubble (throughput 1 per cycle).
REQ-017 busy SHALL be high exactly in state DIV; in_ready SHALL be low in DIV and HOLD.
REQ-018 Input changes while not accepting SHALL have no effect.

Reset
REQ-019 When reset is high at a rising edge, the state SHALL go to IDLE, out_valid to 0, out to 0, busy to 0, and the divide counter to 0.
REQ-020 Reset SHALL abort an in-progress division or held result; no result SHALL emerge afterwards.
REQ-021 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-022 A request presented while reset is high SHALL NOT be accepted.

Structure
REQ-023 Package vector_alu_pkg SHALL hold the op_e enum (the opcodes of REQ-005) and the state_e enum (IDLE, DIV, HOLD).
REQ-024 Sub-module vector_div_lane SHALL implement one lane's iterative divider, with inputs start, a, b and outputs quotient, done; it SHALL be instantiated LANES times with a generate loop.
REQ-025 The shared counter and the FSM SHALL live in vector_alu_pipe; the lanes run in lockstep.

Verification (DATA_WIDTH=8, LANES=6, FRAC_BITS=4)
REQ-026 ADD, lane0 200+100, other lanes 1+2, out_ready=1 -> lane0 result 44, other lanes 3, out_valid after 1 cycle.
REQ-027 SUB lane0 5-9, then MUL 20*13 back-to-back -> 252, then 4, on consecutive cycles with in_ready held 1.
REQ-028 DIV, lanes 100/7 and 5/0 -> 14 and 255; busy high for 8 cycles; out_valid rises 9 cycles after accept; in_ready low throughout.
REQ-029 FPMUL 0x18*0x20 -> 0x30; with out_ready=0 for 5 cycles, out stays stable and in_ready stays 0.
REQ-030 Reset asserted 3 cycles into a DIV -> out_valid never rises for that request; the next ADD 1+1 returns 2.
REQ-031 PASS2 operand2=0xAB in all lanes -> 0xAB in all lanes; op 111 -> operand1 returned.
